// File: rtl/pipeline_controller.sv
// pipeline_controller: merges stall requests, times multi-cycle ops and
// arbitrates trap/mret/jump redirects with registered flush and redirect outputs.
module pipeline_controller #(
    parameter int STAGES       = 6,
    parameter int NUM_SRC      = 2,
    parameter int LVL_W        = 3,
    parameter int ADDR_WIDTH   = 32,
    parameter int JUMP_STAGE   = 2,
    parameter int MC_STAGE     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_SRC-1:0]       stall_req_i,
    input  logic [NUM_SRC*LVL_W-1:0] stall_lvl_i,
    input  logic                     mc_start_i,
    input  logic [7:0]               mc_cycles_i,
    input  logic                     jump_enable_i,
    input  logic [ADDR_WIDTH-1:0]    jump_addr_i,
    input  logic                     mret_i,
    input  logic [ADDR_WIDTH-1:0]    mepc_i,
    input  logic                     irq_i,
    input  logic                     irq_enable_i,
    input  logic [ADDR_WIDTH-1:0]    mtvec_addr_i,
    input  logic                     commit_valid_i,
    input  logic [ADDR_WIDTH-1:0]    commit_pc_i,
    output logic [STAGES-1:0]        stall_o,
    output logic [STAGES-1:0]        flush_o,
    output logic                     redirect_valid_o,
    output logic [ADDR_WIDTH-1:0]    new_pc_o,
    output logic                     trap_taken_o,
    output logic [ADDR_WIDTH-1:0]    trap_epc_o,
    output logic                     busy_o
);
    typedef enum logic [1:0] {RUN, IRQ_WAIT, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              mc_q, mc_d;
    logic [3:0]              fcnt_q, fcnt_d;
    logic [STAGES-1:0]       stall_raw, jump_mask, flush_q, flush_d;
    logic                    redirect_q, redirect_d, trap_q, trap_d;
    logic [ADDR_WIDTH-1:0]   new_pc_q, new_pc_d, epc_q, epc_d;
    logic                    active, irq_pend, irq_take;

    always_comb begin
        stall_raw = '0;
        jump_mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            for (int k = 0; k < NUM_SRC; k++)
                stall_raw[i] = stall_raw[i] | (stall_req_i[k] && int'(stall_lvl_i[k*LVL_W +: LVL_W]) >= i);
            stall_raw[i] = stall_raw[i] | (busy_o && i <= MC_STAGE);
            jump_mask[i] = i >= 1 && i < JUMP_STAGE;
        end
    end

    assign active   = state_q != FLUSH;
    assign busy_o   = |mc_q;
    assign stall_o  = active ? stall_raw : '0;
    assign irq_pend = irq_i & irq_enable_i;
    assign irq_take = active & irq_pend & commit_valid_i & ~busy_o & ~|stall_o & ~jump_enable_i & ~mret_i;

    always_comb begin
        mc_d       = busy_o ? mc_q - 8'd1 : (active && mc_start_i) ? mc_cycles_i : 8'd0;
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        flush_d    = '0;
        redirect_d = 1'b0;
        trap_d     = 1'b0;
        new_pc_d   = new_pc_q;
        epc_d      = epc_q;
        if (!active) begin
            fcnt_d  = fcnt_q - 4'd1;
            flush_d = (fcnt_q > 4'd1) ? '1 : '0;
            state_d = (fcnt_q > 4'd1) ? FLUSH : RUN;
        end else if (irq_take) begin
            state_d    = FLUSH;
            fcnt_d     = 4'(FLUSH_CYCLES);
            flush_d    = '1;
            redirect_d = 1'b1;
            trap_d     = 1'b1;
            new_pc_d   = mtvec_addr_i;
            epc_d      = commit_pc_i;
        end else begin
            state_d = irq_pend ? IRQ_WAIT : RUN;
            if (mret_i || jump_enable_i) begin
                redirect_d = 1'b1;
                new_pc_d   = mret_i ? mepc_i : jump_addr_i;
                flush_d    = jump_mask;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RUN;
            mc_q       <= '0;
            fcnt_q     <= '0;
            flush_q    <= '0;
            redirect_q <= 1'b0;
            trap_q     <= 1'b0;
            new_pc_q   <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            mc_q       <= mc_d;
            fcnt_q     <= fcnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            trap_q     <= trap_d;
            new_pc_q   <= new_pc_d;
            epc_q      <= epc_d;
        end
    end

    assign flush_o          = flush_q;
    assign redirect_valid_o = redirect_q;
    assign new_pc_o         = new_pc_q;
    assign trap_taken_o     = trap_q;
    assign trap_epc_o       = epc_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: stall-mask table, directed corner sequences and a
// randomized run against a behavioural reference model.
module tb_pipeline_controller;
    logic        clk_i = 1'b0, rst_n_i;
    logic [1:0]  stall_req_i;
    logic [5:0]  stall_lvl_i;
    logic        mc_start_i, jump_enable_i, mret_i, irq_i, irq_enable_i, commit_valid_i;
    logic [7:0]  mc_cycles_i;
    logic [31:0] jump_addr_i, mepc_i, mtvec_addr_i, commit_pc_i;
    logic [5:0]  stall_o, flush_o;
    logic        redirect_valid_o, trap_taken_o, busy_o;
    logic [31:0] new_pc_o, trap_epc_o;

    int total = 0, bad = 0;

    pipeline_controller dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_req_i(stall_req_i), .stall_lvl_i(stall_lvl_i),
        .mc_start_i(mc_start_i), .mc_cycles_i(mc_cycles_i), .jump_enable_i(jump_enable_i),
        .jump_addr_i(jump_addr_i), .mret_i(mret_i), .mepc_i(mepc_i), .irq_i(irq_i),
        .irq_enable_i(irq_enable_i), .mtvec_addr_i(mtvec_addr_i), .commit_valid_i(commit_valid_i),
        .commit_pc_i(commit_pc_i), .stall_o(stall_o), .flush_o(flush_o),
        .redirect_valid_o(redirect_valid_o), .new_pc_o(new_pc_o), .trap_taken_o(trap_taken_o),
        .trap_epc_o(trap_epc_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_stall"}, stall_o, 0);
        chk({nm, "_flush"}, flush_o, 0);
        chk({nm, "_rv"}, redirect_valid_o, 0);
        chk({nm, "_pc"}, new_pc_o, 0);
        chk({nm, "_trap"}, trap_taken_o, 0);
        chk({nm, "_epc"}, trap_epc_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
    endtask

    // reference model: remaining op cycles, remaining flush cycles, expected registered outputs
    int          m_mc, m_flush;
    logic [5:0]  e_flush;
    logic        e_rv, e_trap;
    logic [31:0] e_pc, e_epc;

    function automatic logic [5:0] exp_stall();
        int deep = -1;
        if (m_flush > 0) return 6'h0;
        for (int k = 0; k < 2; k++)
            if (stall_req_i[k] && int'(stall_lvl_i[k*3 +: 3]) > deep) deep = int'(stall_lvl_i[k*3 +: 3]);
        if (m_mc > 0 && deep < 3) deep = 3;
        if (deep < 0) return 6'h0;
        if (deep >= 5) return 6'h3f;
        return 6'((1 << (deep + 1)) - 1);
    endfunction

    task automatic model_reset();
        m_mc = 0; m_flush = 0; e_flush = 0; e_rv = 0; e_trap = 0; e_pc = 0; e_epc = 0;
    endtask

    task automatic model_step();
        logic [5:0] s;
        bit take;
        s = exp_stall();
        e_rv = 0;
        e_trap = 0;
        if (m_flush > 0) begin
            m_flush--;
            e_flush = (m_flush > 0) ? 6'h3f : 6'h0;
            if (m_mc > 0) m_mc--;
        end else begin
            take = irq_i && irq_enable_i && commit_valid_i && m_mc == 0 && s == 0 && !jump_enable_i && !mret_i;
            e_flush = 0;
            if (m_mc > 0) m_mc--;
            else if (mc_start_i) m_mc = int'(mc_cycles_i);
            if (take) begin
                m_flush = 2; e_flush = 6'h3f; e_rv = 1; e_trap = 1; e_pc = mtvec_addr_i; e_epc = commit_pc_i;
            end else if (mret_i || jump_enable_i) begin
                e_rv = 1; e_pc = mret_i ? mepc_i : jump_addr_i; e_flush = 6'b000010;
            end
        end
    endtask

    typedef struct {
        logic [1:0] req;
        logic [5:0] lvl;
        logic [5:0] exp;
    } stall_vec_t;

    initial begin
        stall_vec_t tbl[8];
        int n;
        tbl[0] = '{2'b01, {3'd0, 3'd2}, 6'b000111};
        tbl[1] = '{2'b11, {3'd4, 3'd2}, 6'b011111};
        tbl[2] = '{2'b10, {3'd4, 3'd7}, 6'b011111};
        tbl[3] = '{2'b00, {3'd7, 3'd7}, 6'b000000};
        tbl[4] = '{2'b01, {3'd0, 3'd5}, 6'b111111};
        tbl[5] = '{2'b01, {3'd0, 3'd7}, 6'b111111};
        tbl[6] = '{2'b10, {3'd0, 3'd6}, 6'b000001};
        tbl[7] = '{2'b11, {3'd1, 3'd0}, 6'b000011};

        rst_n_i = 0; stall_req_i = 0; stall_lvl_i = 0; mc_start_i = 0; mc_cycles_i = 0;
        jump_enable_i = 0; jump_addr_i = 0; mret_i = 0; mepc_i = 0; irq_i = 0; irq_enable_i = 0;
        mtvec_addr_i = 0; commit_valid_i = 0; commit_pc_i = 0;
        repeat (2) tick();
        chk_zero("reset");
        rst_n_i = 1;
        tick();

        foreach (tbl[i]) begin
            stall_req_i = tbl[i].req;
            stall_lvl_i = tbl[i].lvl;
            #1;
            chk($sformatf("stall_tbl%0d", i), stall_o, tbl[i].exp);
        end
        stall_req_i = 0;

        // multi-cycle op of 3, with a restart attempt while busy
        mc_start_i = 1; mc_cycles_i = 3;
        tick();
        mc_start_i = 0;
        for (int c = 0; c < 3; c++) begin
            chk("mc_busy", busy_o, 1);
            chk("mc_stall", stall_o, 6'b001111);
            mc_start_i = (c == 0); mc_cycles_i = 9;
            tick();
        end
        mc_start_i = 0;
        chk("mc_done_busy", busy_o, 0);
        chk("mc_done_stall", stall_o, 0);

        // jump, then jump+mret
        jump_enable_i = 1; jump_addr_i = 32'h100;
        tick();
        jump_enable_i = 0;
        chk("jmp_rv", redirect_valid_o, 1);
        chk("jmp_pc", new_pc_o, 32'h100);
        chk("jmp_flush", flush_o, 6'b000010);
        tick();
        chk("jmp_rv_clr", redirect_valid_o, 0);
        chk("jmp_flush_clr", flush_o, 0);
        chk("jmp_pc_hold", new_pc_o, 32'h100);
        jump_enable_i = 1; mret_i = 1; mepc_i = 32'h200;
        tick();
        jump_enable_i = 0; mret_i = 0;
        chk("mret_pc", new_pc_o, 32'h200);
        chk("mret_rv", redirect_valid_o, 1);
        tick();

        // interrupt held off by a 4-cycle op
        mc_start_i = 1; mc_cycles_i = 4;
        tick();
        mc_start_i = 0; irq_i = 1; irq_enable_i = 1; commit_valid_i = 1;
        mtvec_addr_i = 32'h80; commit_pc_i = 32'h44;
        n = 0;
        while (!trap_taken_o && n < 12) begin
            tick();
            n++;
        end
        chk("irq_delay", n, 5);
        chk("trap_taken", trap_taken_o, 1);
        chk("trap_rv", redirect_valid_o, 1);
        chk("trap_pc", new_pc_o, 32'h80);
        chk("trap_epc", trap_epc_o, 32'h44);
        chk("trap_flush1", flush_o, 6'h3f);
        irq_i = 0; jump_enable_i = 1; jump_addr_i = 32'h300;
        tick();
        chk("trap_flush2", flush_o, 6'h3f);
        chk("trap_rv2", redirect_valid_o, 0);
        chk("trap_strobe2", trap_taken_o, 0);
        tick();
        jump_enable_i = 0;
        chk("trap_flush3", flush_o, 0);
        chk("trap_jmp_ignored", redirect_valid_o, 0);
        chk("trap_pc_hold", new_pc_o, 32'h80);

        // irq pending behind a stall, then withdrawn
        stall_req_i = 2'b01; stall_lvl_i = 0; irq_i = 1;
        repeat (3) begin
            tick();
            chk("wait_no_trap", trap_taken_o, 0);
        end
        irq_i = 0;
        tick();
        stall_req_i = 0;
        repeat (3) begin
            tick();
            chk("drop_no_trap", trap_taken_o, 0);
            chk("drop_no_rv", redirect_valid_o, 0);
        end
        jump_enable_i = 1; jump_addr_i = 32'h120;
        tick();
        jump_enable_i = 0;
        chk("after_wait_jmp", new_pc_o, 32'h120);

        // reset during FLUSH with the counter live
        irq_i = 1; mc_start_i = 1; mc_cycles_i = 6;
        tick();
        irq_i = 0; mc_start_i = 0;
        chk("rf_trap", trap_taken_o, 1);
        chk("rf_busy", busy_o, 1);
        tick();
        chk("rf_busy5", busy_o, 1);
        chk("rf_stall_forced", stall_o, 0);
        chk("rf_flush", flush_o, 6'h3f);
        #2 rst_n_i = 0;
        #1 chk_zero("async_rst");
        @(negedge clk_i);
        rst_n_i = 1;
        tick();
        chk("post_rst_flush", flush_o, 0);
        mc_start_i = 1; mc_cycles_i = 3;
        tick();
        mc_start_i = 0;
        for (int c = 0; c < 3; c++) begin
            chk("mc2_busy", busy_o, 1);
            chk("mc2_stall", stall_o, 6'b001111);
            tick();
        end
        chk("mc2_done", busy_o, 0);

        // randomized run against the model
        rst_n_i = 0;
        #1 rst_n_i = 1;
        model_reset();
        irq_enable_i = 1;
        for (int it = 0; it < 600; it++) begin
            if (it == 300) begin
                rst_n_i = 0;
                #1 chk_zero("rand_rst");
                model_reset();
                rst_n_i = 1;
            end
            stall_req_i    = {($urandom % 5 == 0), ($urandom % 5 == 0)};
            stall_lvl_i    = 6'($urandom);
            mc_start_i     = ($urandom % 8 == 0);
            mc_cycles_i    = 8'($urandom % 6);
            jump_enable_i  = ($urandom % 6 == 0);
            mret_i         = ($urandom % 9 == 0);
            if ($urandom % 8 == 0) irq_i = ~irq_i;
            irq_enable_i   = ($urandom % 10 != 0);
            commit_valid_i = ($urandom % 4 != 0);
            jump_addr_i    = $urandom & ~32'h3;
            mepc_i         = $urandom & ~32'h3;
            mtvec_addr_i   = $urandom & ~32'h3;
            commit_pc_i    = $urandom & ~32'h3;
            #1;
            chk("r_stall", stall_o, exp_stall());
            model_step();
            @(posedge clk_i);
            #1;
            chk("r_flush", flush_o, e_flush);
            chk("r_rv", redirect_valid_o, e_rv);
            chk("r_trap", trap_taken_o, e_trap);
            chk("r_pc", new_pc_o, e_pc);
            chk("r_busy", busy_o, m_mc != 0);
            if (e_trap) chk("r_epc", trap_epc_o, e_epc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
